// File: rtl/mul4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier; writes the product out as two nibble strobes.
// Optional feature: define MUL4_SEQ_OVF_FLAG_EN to drive ovf during the high-nibble write.
module mul4_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       start,
    output logic [3:0] Out,
    output logic       enable_lo,
    output logic       enable_hi,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WRLO,
        WRHI
    } state_t;

    state_t     state;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [7:0] acc;
    logic [7:0] acc_nxt;
    logic [1:0] cnt;

    always_comb begin
        acc_nxt = acc;
        if (b_reg[cnt]) begin
            acc_nxt = acc + ({4'b0000, a_reg} << cnt);
        end
    end

    // Outputs are registered alongside the state transition, so each one is
    // valid for exactly the cycle its state is held (Moore timing preserved).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            Out       <= '0;
            enable_lo <= 1'b0;
            enable_hi <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef MUL4_SEQ_OVF_FLAG_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        Out       <= acc_nxt[3:0];
                        enable_lo <= 1'b1;
                        state     <= WRLO;
                    end
                end
                WRLO: begin
                    Out       <= acc[7:4];
                    enable_lo <= 1'b0;
                    enable_hi <= 1'b1;
                    done      <= 1'b1;
`ifdef MUL4_SEQ_OVF_FLAG_EN
                    ovf       <= (acc[7:4] != 4'h0);
`endif
                    state     <= WRHI;
                end
                WRHI: begin
                    Out       <= '0;
                    enable_hi <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
`ifdef MUL4_SEQ_OVF_FLAG_EN
                    ovf       <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef MUL4_SEQ_OVF_FLAG_EN
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/mul4_seq.md
MUL4_SEQ -- requirements
Module: mul4_seq

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, single clock, all state changes on the rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-003 The block SHALL have these ports: A, input, 4, multiplicand; sampled only on the start edge.
REQ-004 The block SHALL have these ports: B, input, 4, multiplier; sampled only on the start edge.
REQ-005 The block SHALL have these ports: start, input, 1, request a multiply; honoured only in IDLE.
REQ-006 The block SHALL have these ports: Out, output, 4, product nibble feeding the downstream 4-bit enable register(s).
REQ-007 The block SHALL have these ports: enable_lo, output, 1, one-cycle write strobe; Out holds product[3:0].
REQ-008 The block SHALL have these ports: enable_hi, output, 1, one-cycle write strobe; Out holds product[7:4].
REQ-009 The block SHALL have these ports: busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have these ports: done, output, 1, one-cycle pulse coincident with enable_hi.
REQ-011 The block SHALL have these ports: ovf, output, 1, product exceeds 4 bits; behaviour per Configuration.

Function
REQ-012 The block SHALL implement a Moore FSM with states IDLE, CALC, WRLO and WRHI; all outputs SHALL be decoded from registered state only.
REQ-013 In IDLE with start=1 at edge N, the block SHALL latch A and B, clear the 8-bit accumulator acc and the 2-bit counter cnt, and enter CALC.
REQ-014 In CALC, each edge SHALL add ({4'b0,A_reg} << cnt) to acc when B_reg[cnt]=1, then increment cnt; at the edge where cnt=3 the block SHALL enter WRLO.
REQ-015 The accumulator arithmetic SHALL be unsigned 8-bit; the product SHALL never exceed 225, and acc SHALL not wrap.
REQ-016 The state sequence SHALL be: WRLO after edge N+4, WRHI after edge N+5, IDLE after edge N+6; the latency from the start edge to enable_lo SHALL be 4 edges, with exactly 6 cycles of busy.
REQ-017 In WRLO, the block SHALL drive Out=acc[3:0] and enable_lo=1; in WRHI, it SHALL drive Out=acc[7:4], enable_hi=1 and done=1.
REQ-018 In IDLE and CALC, the block SHALL drive Out=4'b0000, enable_lo=0, enable_hi=0 and done=0.
REQ-019 enable_lo and enable_hi SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per accepted start.
REQ-020 start while busy=1, including during WRHI, SHALL be ignored with no queuing; start in the first IDLE cycle after WRHI SHALL be accepted.
REQ-021 A and B changing after the start edge SHALL NOT affect the result.

Reset
REQ-022 Asserting reset SHALL immediately, without waiting for clk, force the state to IDLE and set acc=0, cnt=0, A_reg=0, B_reg=0, Out=0, enable_lo=0, enable_hi=0, busy=0, done=0 and ovf=0.
REQ-023 Reset asserted mid-operation SHALL abort the operation, and no enable strobe SHALL be issued for the aborted operation.
REQ-024 A start that coincides with reset SHALL be ignored, and the first start SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-025 With the macro MUL4_SEQ_OVF_FLAG_EN defined, ovf SHALL equal (acc[7:4] != 0) during WRHI and SHALL be 0 in all other states.
REQ-026 Without MUL4_SEQ_OVF_FLAG_EN, the ovf port SHALL still exist, SHALL be tied to 0, and no overflow logic SHALL be synthesised.

Verification
REQ-027 The bench SHALL cover: A=3, B=5, start pulse -> enable_lo with Out=4'hF, then enable_hi with Out=4'h0 and done=1, ovf=0.
REQ-028 The bench SHALL cover: A=15, B=15 -> Out=4'h1 on enable_lo and Out=4'hE on enable_hi; ovf=1 with the macro defined and ovf=0 without it.
REQ-029 The bench SHALL cover: A=7, B=0 -> both strobes fire with Out=0, and busy stays high for exactly 6 cycles.
REQ-030 The bench SHALL cover: start plus A=2, B=3, then start re-pulsed with A=9, B=9 during CALC and during WRHI -> a single result of 6, with the later starts ignored.
REQ-031 The bench SHALL cover: reset asserted between clock edges in CALC -> busy=0 immediately, and no enable_lo or enable_hi is issued.
REQ-032 The bench SHALL cover: back-to-back operations with start asserted in the IDLE cycle right after done -> the second result is correct, with no gap beyond one IDLE cycle.
